cpu_ctrl_fsm: RTL

- Instruction-sequencing controller for the 8-bit accumulator CPU.
- Sits directly downstream of the clock generator and consumes its `fetch` strobe; one instruction spans 8 `clk` cycles, one fetch period.
- Steps an 8-state sequence per instruction and drives the PC, IR, accumulator, memory and data-bus control strobes from `opcode` and `zero`.

---
 rtl/cpu_ctrl_pkg.sv | 27 ++
 rtl/cpu_ctrl_decode.sv | 32 +++
 rtl/cpu_ctrl_fsm.sv | 90 +++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode encodings, sequencer states and control-word bit layout for cpu_ctrl_fsm
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam int CW_INC_PC   = 0;
    localparam int CW_LOAD_PC  = 1;
    localparam int CW_LOAD_IR  = 2;
    localparam int CW_LOAD_ACC = 3;
    localparam int CW_RD       = 4;
    localparam int CW_WR       = 5;
    localparam int CW_DATACTL  = 6;
    localparam int CW_HALT     = 7;
    localparam int CW_W        = 8;

    typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational (state, opcode, zero) -> control word
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [2:0] opcode_i,
    input  logic       zero_i,
    output cw_t        cw_o
);

    logic alu, sto, jmp, skip, fetch_ph;

    assign alu      = opcode_i inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    assign sto      = opcode_i == OP_STO;
    assign jmp      = opcode_i == OP_JMP;
    assign skip     = opcode_i == OP_SKZ && zero_i;
    assign fetch_ph = state_i == S0 || state_i == S1;

    // S0/S1 fetch the two IR bytes; S3..S7 execute according to the opcode
    always_comb begin
        cw_o = '0;
        cw_o[CW_INC_PC]   = fetch_ph || (state_i == S5 && (jmp || skip)) || (state_i == S7 && skip);
        cw_o[CW_LOAD_PC]  = (state_i == S4 || state_i == S5) && jmp;
        cw_o[CW_LOAD_IR]  = fetch_ph;
        cw_o[CW_LOAD_ACC] = state_i == S5 && alu;
        cw_o[CW_RD]       = fetch_ph || (state_i inside {S4, S5, S6} && alu);
        cw_o[CW_WR]       = state_i == S6 && sto;
        cw_o[CW_DATACTL]  = state_i inside {S4, S5, S6, S7} && sto;
        cw_o[CW_HALT]     = state_i == S3 && opcode_i == OP_HLT;
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: 8-step instruction sequencer started by fetch edges; optional resume port via CPU_CTRL_RESUME_EN
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 3
) (
    input  logic            clk,
    input  logic            reset,
`ifdef CPU_CTRL_RESUME_EN
    input  logic            resume,
`endif
    input  logic            fetch,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_acc,
    output logic            rd,
    output logic            wr,
    output logic            datactl_ena,
    output logic            halt,
    output logic            busy
);

    state_t state_q, state_d;
    logic   running_q, running_d;
    logic   halted_q, halted_d;
    logic   fetch_q;
    cw_t    cw;

    cpu_ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .zero_i   (zero),
        .cw_o     (cw)
    );

    // State register with synchronous reset; fetch_q tracks fetch for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            fetch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            fetch_q   <= fetch;
        end
    end

    // Next state: hold while halted, step while running, arm on a fetch rising edge when idle
    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        halted_d  = halted_q;
        if (halted_q) begin
`ifdef CPU_CTRL_RESUME_EN
            if (resume) begin
                halted_d  = 1'b0;
                running_d = 1'b0;
            end
`endif
        end else if (running_q) begin
            if (cw[CW_HALT]) begin
                halted_d  = 1'b1;
                running_d = 1'b0;
                state_d   = S0;
            end else begin
                state_d = state_t'(state_q + 3'd1);
            end
        end else if (fetch && !fetch_q) begin
            running_d = 1'b1;
            state_d   = S0;
        end
    end

    assign inc_pc      = running_q & cw[CW_INC_PC];
    assign load_pc     = running_q & cw[CW_LOAD_PC];
    assign load_ir     = running_q & cw[CW_LOAD_IR];
    assign load_acc    = running_q & cw[CW_LOAD_ACC];
    assign rd          = running_q & cw[CW_RD];
    assign wr          = running_q & cw[CW_WR];
    assign datactl_ena = running_q & cw[CW_DATACTL];
    assign halt        = halted_q | (running_q & cw[CW_HALT]);
    assign busy        = running_q;

endmodule
